// File: rtl/eth_decap.sv
// Receive-side TLP-over-Ethernet decapsulator: validates and strips the 16-byte header, buffers
// each frame's payload, and releases only complete good frames to the eth2pcie FIFO.
module eth_decap #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          BUF_AW    = 6
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [31:0] cnt_ok,
  output logic [31:0] cnt_fmt,
  output logic [31:0] cnt_err,
  output logic [31:0] cnt_ovf
);
  typedef enum logic [1:0] {HDR0, HDR1, PAY, DROP} state_t;

  localparam int              DEPTH   = 1 << BUF_AW;
  localparam logic [BUF_AW:0] PTR_ONE = {{BUF_AW{1'b0}}, 1'b1};

  state_t          state_q;
  logic            sop_q;
  logic [BUF_AW:0] rp_q, wps_q, wpc_q, wps_inc, rp_d;
  logic [73:0]     mem_q [DEPTH];
  logic [31:0]     ok_q, fmt_q, err_q, ovf_q;
  logic            free, et_ok, wr_mem;

  assign wps_inc = wps_q + PTR_ONE;
  // One slot stays unused so a full buffer is distinguishable from an empty one.
  assign free    = wps_inc[BUF_AW-1:0] != rp_q[BUF_AW-1:0];
  assign et_ok   = {s_axis_tdata[39:32], s_axis_tdata[47:40]} == ETHERTYPE;
  assign wr_mem  = s_axis_tvalid && (state_q == PAY) && free;

  assign wr_en   = (rp_q != wpc_q) && !full;
  assign din     = mem_q[rp_q[BUF_AW-1:0]];
  assign rp_d    = wr_en ? rp_q + PTR_ONE : rp_q;

  assign cnt_ok  = ok_q;
  assign cnt_fmt = fmt_q;
  assign cnt_err = err_q;
  assign cnt_ovf = ovf_q;

  // Speculative writes land beyond wp_cmt, so they stay invisible until committed.
  always_ff @(posedge clk156) begin
    if (wr_mem)
      mem_q[wps_q[BUF_AW-1:0]] <= {sop_q, s_axis_tlast,
                                   s_axis_tlast ? s_axis_tkeep : 8'hFF, s_axis_tdata};
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) rp_q <= '0;
    else         rp_q <= rp_d;
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q <= HDR0;
      sop_q   <= 1'b0;
      wps_q   <= '0;
      wpc_q   <= '0;
      ok_q    <= '0;
      fmt_q   <= '0;
      err_q   <= '0;
      ovf_q   <= '0;
    end else if (s_axis_tvalid) begin
      case (state_q)
        HDR0: begin
          if (s_axis_tlast) fmt_q   <= fmt_q + 32'd1;
          else              state_q <= HDR1;
        end
        HDR1: begin
          if (s_axis_tlast) begin
            fmt_q   <= fmt_q + 32'd1;
            state_q <= HDR0;
          end else if (!et_ok) begin
            fmt_q   <= fmt_q + 32'd1;
            state_q <= DROP;
          end else begin
            sop_q   <= 1'b1;
            state_q <= PAY;
          end
        end
        PAY: begin
          sop_q <= 1'b0;
          if (s_axis_tlast) begin
            state_q <= HDR0;
            if (!s_axis_tuser) begin
              wps_q <= wpc_q;
              err_q <= err_q + 32'd1;
            end else if (!free) begin
              wps_q <= wpc_q;
              ovf_q <= ovf_q + 32'd1;
            end else begin
              wps_q <= wps_inc;
              wpc_q <= wps_inc;
              ok_q  <= ok_q + 32'd1;
            end
          end else if (!free) begin
            wps_q   <= wpc_q;
            ovf_q   <= ovf_q + 32'd1;
            state_q <= DROP;
          end else begin
            wps_q <= wps_inc;
          end
        end
        DROP: begin
          if (s_axis_tlast) state_q <= HDR0;
        end
        default: state_q <= HDR0;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_decap.sv
// Bench for eth_decap: random frames scored against a frame-level model of the
// accept/drop rules and buffer capacity; output words checked in order by a monitor.
module tb_eth_decap;
  localparam logic [15:0] ETH = 16'h88B5;
  localparam int          CAP = 15;  // 2**4 - 1 usable slots with BUF_AW=4

  logic        clk = 1'b0, sys_rst = 1'b1, full = 1'b0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        wr_en;
  logic [73:0] din;
  logic [31:0] cnt_ok, cnt_fmt, cnt_err, cnt_ovf;

  int          total = 0, bad = 0, words = 0;
  logic [73:0] exp_q[$];
  logic [73:0] mon_e;
  logic [31:0] m_ok = 0, m_fmt = 0, m_err = 0, m_ovf = 0;
  logic        tog_en = 1'b0;

  eth_decap #(.ETHERTYPE(ETH), .BUF_AW(4)) dut (
    .clk156(clk), .sys_rst(sys_rst),
    .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .wr_en(wr_en), .din(din), .full(full),
    .cnt_ok(cnt_ok), .cnt_fmt(cnt_fmt), .cnt_err(cnt_err), .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tog_en) begin #1 full = ~full; end

  always @(negedge clk) begin
    if (!sys_rst && wr_en === 1'b1) begin
      total++;
      if (full) begin
        bad++; $display("FAIL write_while_full wr_en=1 full=%b need no write", full);
      end else if (exp_q.size() == 0) begin
        bad++; $display("FAIL unexpected_word got=%h need none", din);
      end else begin
        mon_e = exp_q.pop_front();
        words++;
        if (din !== mon_e) begin
          bad++; $display("FAIL out_word got=%h need=%h", din, mon_e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    @(posedge clk); #1;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tuser = u;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      tvalid = 1'b0; tdata = {$urandom(), $urandom()}; tlast = 1'($urandom()); tuser = 1'($urandom());
    end
  endtask

  // Drives one frame of nb beats (2 header + payload) and applies the frame-level rules.
  task automatic send_frame(input logic [15:0] et, input int nb, input logic tu,
                            input logic [7:0] lk, input int gap);
    logic [73:0] w[$];
    logic [63:0] d;
    logic [7:0]  kr;
    logic        last, first;
    int          np, k;
    np = nb - 2;
    k  = CAP - exp_q.size();  // payload index that first finds no free slot
    for (int i = 0; i < nb; i++) begin
      if (i > 0 && $urandom_range(99) < gap) idle($urandom_range(1, 3));
      d = {$urandom(), $urandom()};
      if (i == 1) begin d[39:32] = et[15:8]; d[47:40] = et[7:0]; end
      last = (i == nb - 1); first = (i == 2); kr = 8'($urandom());
      beat(d, last ? lk : kr, last, last ? tu : 1'($urandom()));
      if (i >= 2) w.push_back({first, last, last ? lk : 8'hFF, d});
    end
    if (nb <= 2 || et != ETH) m_fmt++;
    else if (k < np - 1)      m_ovf++;
    else if (!tu)             m_err++;
    else if (k == np - 1)     m_ovf++;
    else begin
      m_ok++;
      foreach (w[j]) exp_q.push_back(w[j]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_timeout left=%0d need=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; full = 1'b0;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    total += 5;
    if (wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%b need=0", wr_en); end
    if (cnt_ok !== 32'd0)  begin bad++; $display("FAIL reset_cnt_ok got=%0d need=0", cnt_ok); end
    if (cnt_fmt !== 32'd0) begin bad++; $display("FAIL reset_cnt_fmt got=%0d need=0", cnt_fmt); end
    if (cnt_err !== 32'd0) begin bad++; $display("FAIL reset_cnt_err got=%0d need=0", cnt_err); end
    if (cnt_ovf !== 32'd0) begin bad++; $display("FAIL reset_cnt_ovf got=%0d need=0", cnt_ovf); end
  endtask

  task automatic test_good();
    int w0 = words;
    send_frame(ETH, 6, 1'b1, 8'h0F, 0);
    idle(1);
    total += 3;
    if (wr_en !== 1'b1) begin bad++; $display("FAIL good_latency wr_en=%b need=1", wr_en); end
    if (din[73] !== 1'b1) begin bad++; $display("FAIL good_sop got=%b need=1", din[73]); end
    if (exp_q.size() == 0 || din !== exp_q[0]) begin
      bad++; $display("FAIL good_first_word got=%h need model head", din);
    end
    drain();
    total += 2;
    if (words - w0 != 4) begin bad++; $display("FAIL good_words got=%0d need=4", words - w0); end
    if (cnt_ok !== m_ok) begin bad++; $display("FAIL good_cnt_ok got=%0d need=%0d", cnt_ok, m_ok); end
  endtask

  task automatic test_err();
    send_frame(ETH, 6, 1'b0, 8'h0F, 0);
    idle(2);
    total += 2;
    if (wr_en !== 1'b0) begin bad++; $display("FAIL err_no_output wr_en=%b need=0", wr_en); end
    if (cnt_err !== m_err) begin bad++; $display("FAIL err_cnt got=%0d need=%0d", cnt_err, m_err); end
    send_frame(ETH, 5, 1'b1, 8'h3F, 0);
    idle(1);
    drain();
    total += 2;
    if (cnt_ok !== m_ok)   begin bad++; $display("FAIL err_next_ok got=%0d need=%0d", cnt_ok, m_ok); end
    if (cnt_err !== m_err) begin bad++; $display("FAIL err_cnt2 got=%0d need=%0d", cnt_err, m_err); end
  endtask

  task automatic test_fmt();
    send_frame(16'h0800, 6, 1'b1, 8'hFF, 0);
    send_frame(ETH, 2, 1'b1, 8'hFF, 0);
    send_frame(ETH, 1, 1'b1, 8'hFF, 0);
    idle(3);
    total += 3;
    if (wr_en !== 1'b0)    begin bad++; $display("FAIL fmt_no_output wr_en=%b need=0", wr_en); end
    if (cnt_fmt !== m_fmt) begin bad++; $display("FAIL fmt_cnt got=%0d need=%0d", cnt_fmt, m_fmt); end
    if (cnt_ok !== m_ok)   begin bad++; $display("FAIL fmt_cnt_ok got=%0d need=%0d", cnt_ok, m_ok); end
  endtask

  task automatic test_ovf();
    int w0;
    full = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(ETH, 8, 1'b1, 8'hFF, 0);
    idle(2);
    total += 3;
    if (cnt_ovf !== m_ovf) begin bad++; $display("FAIL ovf_cnt got=%0d need=%0d", cnt_ovf, m_ovf); end
    if (cnt_ok !== m_ok)   begin bad++; $display("FAIL ovf_cnt_ok got=%0d need=%0d", cnt_ok, m_ok); end
    if (wr_en !== 1'b0)    begin bad++; $display("FAIL ovf_held wr_en=%b need=0", wr_en); end
    w0 = words;
    full = 1'b0;
    drain();
    total++;
    if (words - w0 != 12) begin bad++; $display("FAIL ovf_release_words got=%0d need=12", words - w0); end
    // Boundaries: 16 payload beats never fit, 15 fit exactly into an empty buffer.
    send_frame(ETH, 18, 1'b1, 8'hFF, 0);
    send_frame(ETH, 18, 1'b0, 8'hFF, 0);
    send_frame(ETH, 17, 1'b1, 8'h01, 0);
    idle(1);
    drain();
    total += 3;
    if (cnt_ovf !== m_ovf) begin bad++; $display("FAIL ovf_big_cnt got=%0d need=%0d", cnt_ovf, m_ovf); end
    if (cnt_err !== m_err) begin bad++; $display("FAIL ovf_big_err got=%0d need=%0d", cnt_err, m_err); end
    if (cnt_ok !== m_ok)   begin bad++; $display("FAIL ovf_exact_fit got=%0d need=%0d", cnt_ok, m_ok); end
  endtask

  task automatic test_rst_mid();
    full = 1'b1;
    send_frame(ETH, 4, 1'b1, 8'hFF, 0);
    beat({$urandom(), $urandom()}, 8'hFF, 1'b0, 1'b0);
    beat({16'h0, ETH[7:0], ETH[15:8], 32'h0}, 8'hFF, 1'b0, 1'b0);
    beat({$urandom(), $urandom()}, 8'hFF, 1'b0, 1'b0);
    beat({$urandom(), $urandom()}, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    sys_rst = 1'b1; tvalid = 1'b0;
    exp_q.delete();
    m_ok = 0; m_fmt = 0; m_err = 0; m_ovf = 0;
    @(posedge clk); #1;
    sys_rst = 1'b0; full = 1'b0;
    total += 3;
    if (wr_en !== 1'b0)   begin bad++; $display("FAIL rstmid_wr_en got=%b need=0", wr_en); end
    if (cnt_ok !== 32'd0) begin bad++; $display("FAIL rstmid_cnt_ok got=%0d need=0", cnt_ok); end
    if ({cnt_fmt, cnt_err, cnt_ovf} !== 96'd0) begin
      bad++; $display("FAIL rstmid_cnts got=%0d/%0d/%0d need=0", cnt_fmt, cnt_err, cnt_ovf);
    end
    idle(4);
    send_frame(ETH, 5, 1'b1, 8'h07, 0);
    idle(1);
    drain();
    total++;
    if (cnt_ok !== 32'd1) begin bad++; $display("FAIL rstmid_next_ok got=%0d need=1", cnt_ok); end
  endtask

  task automatic test_gaps();
    int r, nb;
    tog_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      r  = $urandom_range(9);
      nb = 2 + $urandom_range(1, 6);
      case (r)
        0:       send_frame(16'($urandom()) | 16'h0001 ^ 16'h0000, nb, 1'b1, 8'hFF, 40);
        1:       send_frame(ETH, $urandom_range(1, 2), 1'b1, 8'hFF, 40);
        2:       send_frame(ETH, nb, 1'b0, 8'h03, 40);
        default: send_frame(ETH, nb, 1'b1, 8'(1 << $urandom_range(7)) | 8'h01, 40);
      endcase
      idle(1);
      drain();
    end
    tog_en = 1'b0;
    @(posedge clk); #1 full = 1'b0;
    total += 4;
    if (cnt_ok !== m_ok)   begin bad++; $display("FAIL gaps_cnt_ok got=%0d need=%0d", cnt_ok, m_ok); end
    if (cnt_fmt !== m_fmt) begin bad++; $display("FAIL gaps_cnt_fmt got=%0d need=%0d", cnt_fmt, m_fmt); end
    if (cnt_err !== m_err) begin bad++; $display("FAIL gaps_cnt_err got=%0d need=%0d", cnt_err, m_err); end
    if (cnt_ovf !== m_ovf) begin bad++; $display("FAIL gaps_cnt_ovf got=%0d need=%0d", cnt_ovf, m_ovf); end
  endtask

  task automatic test_back_to_back();
    int w0 = words, n = 0;
    for (int f = 0; f < 6; f++) begin
      send_frame(ETH, 3 + f % 3, 1'b1, 8'hFF, 0);
      n += 1 + f % 3;
    end
    idle(1);
    drain();
    total += 2;
    if (words - w0 != n) begin bad++; $display("FAIL b2b_words got=%0d need=%0d", words - w0, n); end
    if (cnt_ok !== m_ok) begin bad++; $display("FAIL b2b_cnt_ok got=%0d need=%0d", cnt_ok, m_ok); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_err();
    test_fmt();
    test_ovf();
    test_rst_mid();
    test_gaps();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
